// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings: multiply/divide opcodes and FSM states
package alu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier / restoring divider with HI/LO results
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_e             state, state_next;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic               res_sign, rem_sign;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_a, add_b;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH:0]     mul_t;
    logic [2*WIDTH-1:0] prod;

    assign is_div    = op_r[1];
    assign is_signed = ~op_r[0];
    assign a_mag     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
    assign b_mag     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
    assign prod      = {acc_hi, acc_lo};

    // One shared adder: multiply adds the multiplicand to the upper half,
    // divide subtracts the divisor from the shifted remainder (carry-out = no borrow).
    assign add_a = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
    assign add_b = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
    assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};
    assign mul_t = acc_lo[0] ? sum[WIDTH:0] : {1'b0, acc_hi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH-1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            res_sign    <= 1'b0;
            rem_sign    <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r        <= op;
                        a_r         <= a;
                        b_r         <= b;
                        div_by_zero <= 1'b0;
                    end
                end
                PREP: begin
                    acc_hi   <= '0;
                    acc_lo   <= is_div ? a_mag : b_mag;
                    opnd     <= is_div ? b_mag : a_mag;
                    res_sign <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    rem_sign <= is_signed & a_r[WIDTH-1];
                    cnt      <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], sum[WIDTH+1]};
                    end else begin
                        acc_hi <= mul_t[WIDTH:1];
                        acc_lo <= {mul_t[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (b_r == '0) begin
                            lo          <= '1;
                            hi          <= a_r;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo <= res_sign ? -acc_lo : acc_lo;
                            hi <= rem_sign ? -acc_hi : acc_hi;
                        end
                    end else begin
                        {hi, lo} <= res_sign ? -prod : prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv at WIDTH=32 and WIDTH=8
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start8;
    logic [1:0]  op, op8;
    logic [31:0] a, b, hi, lo;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy, done, dbz, busy8, done8, dbz8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dbz = 1'b0;
        case (o)
            OP_MULT:  begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_MULTU: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (y == 32'b0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    q = sx / sy; r = sx % sy; e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input exp_t e, input bit push);
        if (push) sbq.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic complete(input string tag);
        exp_t e;
        int   n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check({tag, "_latency"}, 64'(cyc - start_cyc), 64'd34);
        if (sbq.size() > 0) e = sbq.pop_front();
        else begin e.hi = 'x; e.lo = 'x; e.dbz = 1'bx; end
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        check({tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        issue(o, x, y, e, 1'b1);
        complete(tag);
    endtask

    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo,
                        input logic edbz);
        exp_t e;
        int   s, n;
        e.hi = {24'b0, ehi}; e.lo = {24'b0, elo}; e.dbz = edbz;
        sbq.push_back(e);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk);
        #1;
        s = cyc;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done8) break;
        end
        check({tag, "_latency"}, 64'(cyc - s), 64'd10);
        e = sbq.pop_front();
        check({tag, "_hi"}, 64'(hi8), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo8), 64'(e.lo));
        check({tag, "_dbz"}, 64'(dbz8), 64'(e.dbz));
        @(posedge clk);
        #1;
        check({tag, "_busy_fall"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 2'b0; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_ctrl", {61'd0, busy, done, dbz}, 64'd0);
        check("reset_state8", {45'd0, hi8, lo8, busy8, done8, dbz8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run("multu_after_dbz", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        run("div_zero_neg", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            e = model(ro, ra, rb);
            issue(ro, ra, rb, e, 1'b1);
            complete($sformatf("rand%0d", i));
        end

        e.hi = 32'd0; e.lo = 32'h0001_2340; e.dbz = 1'b0;
        issue(OP_MULTU, 32'h0000_1234, 32'h0000_0010, e, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        complete("ignore_start");

        e.hi = 32'd1; e.lo = 32'd333; e.dbz = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd3, e, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_data", {hi, lo}, 64'd0);
        check("midreset_ctrl", {61'd0, busy, done, dbz}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (done || busy) seen++;
            end
            check("midreset_no_done", 64'(seen), 64'd0);
        end
        run("after_reset", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        run8("w8_mult", OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
        run8("w8_div_ovf", OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        run8("w8_multu", OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
        run8("w8_div_zero", OP_DIV, 8'h85, 8'h00, 8'h85, 8'hFF, 1'b1);
        run8("w8_divu", OP_DIVU, 8'd200, 8'd7, 8'd4, 8'd28, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
